sound_scheduler: RTL and testbench
==================================

# sound_scheduler

Schedules playback of one shared audio clip player between several game-event requesters. Latches single-cycle event requests as pending. Grants the highest-priority pending request, then drives the player through a per-clip number of repetitions separated by a silent gap. Sits between the game state logic (event pulses, state-change flush, mute) and the clip player (start/stop/done handshake).

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 is highest priority
- ID_W, 3, clip-id width on the player port
- GAP_CYCLES, 1000, idle CLK cycles between repetitions (≥1)
- TIMEOUT, 0, max CLK cycles in PLAY before forced abort; 0 disables the watchdog

Ports:
- CLK  in  1  system clock; all logic rises on posedge CLK
- rst_n  in  1  reset, asynchronous and active-low
- req  in  N_REQ  per-requester event pulses; a 1 on any cycle sets that requester's pending bit
- flush  in  1  game state changed; clears all pending bits except the granted one
- mute  in  1  level; aborts the current clip and blocks new requests while high
- play_start  out  1  one-cycle pulse: player starts clip play_id
- play_stop  out  1  one-cycle pulse: player aborts immediately
- play_id  out  ID_W  clip id; valid from play_start until return to IDLE
- play_done  in  1  one-cycle pulse from the player at clip end
- busy  out  1  high in every state except IDLE
- active_req  out  N_REQ  one-hot granted requester; 0 when idle
- rep_cnt  out  2  repetitions completed for the current grant

## Operation
- Pending register, N_REQ bits:
  - set by req[i] when mute=0
  - cleared for the granted index on the final play_done
  - cleared for non-granted indices by flush
  - cleared entirely by mute
- Same-cycle priority:
  - flush+req on the same index: cleared; the request is dropped
  - final-done clear + req on the granted index: stays set; the clip replays later
- States:
  - IDLE: if pending≠0 and mute=0, latch the grant (lowest set index) into active_req. Latch play_id=CLIP_ID[grant] and reps=CLIP_REPS[grant]. Set rep_cnt=0, go to START.
  - START: play_start=1 for exactly one cycle, then go to PLAY. play_done here is ignored.
  - PLAY: wait for play_done.
    - On done, rep_cnt+1 is registered.
    - If rep_cnt+1 == reps: clear the pending bit, active_req←0, go to IDLE.
    - Otherwise load the gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: count down to 0, then go to START. play_done is ignored.
- mute=1 in START, PLAY or GAP: play_stop pulses one cycle. Next state is IDLE with active_req=0 and pending=0. No play_start on that cycle.
- Watchdog (TIMEOUT≠0): counter cleared on START and incremented each cycle in PLAY. When it reaches TIMEOUT-1 without done: play_stop pulses and the event counts as play_done for repetition accounting.
- No preemption: a higher-priority request waits until the current grant finishes all repetitions.
- CLIP_REPS range 1..4, stored as reps-1 in 2 bits. rep_cnt saturates at 3 and never wraps.

## Timing
- Reset values: play_start=0, play_stop=0, play_id=0, busy=0, active_req=0, rep_cnt=0, pending=0, state IDLE. Reset mid-clip issues no play_stop.
- Latency: req pulse at cycle t → pending at t+1 → START (play_start high) at t+2, when idle.
- Back-to-back: the last play_done at cycle t gives IDLE at t+1 and the next play_start at t+2.
- Inter-repetition: play_done at cycle t → next play_start at t+GAP_CYCLES+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package sound_pkg:
  - state enum (IDLE, START, PLAY, GAP)
  - CLIP_ID[N_REQ] and CLIP_REPS[N_REQ] constant arrays
  - the clip id for game-over
- One natural sub-module: prio_pick, a combinational lowest-index one-hot selector with a valid flag. It is reusable by other arbiters.

## Test plan
- Single request: req[2] pulse at t, CLIP_REPS[2]=3, GAP_CYCLES=4.
  - play_start at t+2, play_id=CLIP_ID[2]; done 10 cycles later.
  - Three play_start pulses, each 5 cycles after the previous done. rep_cnt steps 1,2,3; busy falls after the third done.
- Priority: req[3] and req[1] in the same cycle → req[1] clip fully served first, then req[3] starts 2 cycles after the last done.
- Flush: req[0] playing, req[2] pending, flush pulse → req[0] completes normally; req[2] never starts; busy=0 afterward.
- Mute mid-play: mute raised in PLAY → play_stop at the next edge; IDLE, pending=0. req pulses while mute=1 are ignored after mute falls.
- Watchdog: TIMEOUT=20, player never returns done → play_stop 20 cycles after play_start; the repetition counts and the next repetition follows after the gap.
- Async reset in GAP: rst_n low mid-cycle → all outputs 0 immediately; no play_start until a new req.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and clip tables for the sound scheduler and related audio arbiters.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int MAX_REQ   = 8;
    localparam int CLIP_ID_W = 3;

    localparam logic [CLIP_ID_W-1:0] CLIP_GAME_OVER = 3'd5;

    // Index 0 is the highest-priority requester; tables list index MAX_REQ-1 first.
    localparam logic [MAX_REQ-1:0][CLIP_ID_W-1:0] CLIP_ID = {
        3'd1, 3'd7, 3'd4, 3'd0, 3'd6, 3'd3, 3'd2, CLIP_GAME_OVER
    };

    // Stored as repetitions-1, so 2'd3 means four plays.
    localparam logic [MAX_REQ-1:0][1:0] CLIP_REPS = {
        2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0
    };

endpackage

// File: rtl/sound_scheduler_prio_pick.sv
// Lowest-index-wins one-hot selector with a valid flag; purely combinational.
module prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    // x & -x isolates the lowest set bit.
    assign o_grant = i_req & (~i_req + N'(1));
    assign o_valid = |i_req;

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates one clip player between event requesters: latch, grant by priority,
// play the clip a per-clip number of times with a silent gap, abort on mute or watchdog.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 3,
    parameter int GAP_CYCLES = 1000,
    parameter int TIMEOUT    = 0
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             flush,
    input  logic             mute,
    output logic             play_start,
    output logic             play_stop,
    output logic [ID_W-1:0]  play_id,
    input  logic             play_done,
    output logic             busy,
    output logic [N_REQ-1:0] active_req,
    output logic [1:0]       rep_cnt
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             r_state;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   r_active;
    logic [ID_W-1:0]    r_play_id;
    logic [1:0]         r_reps_m1;
    logic [1:0]         r_rep_cnt;
    logic               r_play_start;
    logic               r_play_stop;
    logic [GAP_W-1:0]   r_gap;
    logic [WD_W-1:0]    r_wd;

    logic [N_REQ-1:0]   w_pick;
    logic               w_pick_valid;
    logic [ID_W-1:0]    w_pick_id;
    logic [1:0]         w_pick_reps;
    logic               w_grant_go;
    logic               w_abort;
    logic               w_timeout;
    logic               w_done;
    logic               w_final;
    logic [N_REQ-1:0]   w_keep;
    logic [N_REQ-1:0]   w_pend_next;

    prio_pick #(.N(N_REQ)) u_pick (
        .i_req   (r_pending),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_id   = '0;
        w_pick_reps = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_id   = ID_W'(CLIP_ID[i]);
                w_pick_reps = CLIP_REPS[i];
            end
        end
    end

    assign w_grant_go = (r_state == ST_IDLE) && w_pick_valid && !mute;
    assign w_abort    = mute && (r_state != ST_IDLE);
    assign w_timeout  = (TIMEOUT != 0) && (r_state == ST_PLAY) && (r_wd == WD_W'(TIMEOUT - 1));
    assign w_done     = (r_state == ST_PLAY) && !mute && (play_done || w_timeout);
    assign w_final    = w_done && (r_rep_cnt == r_reps_m1);

    // The grant being latched this cycle is protected from flush just like the current one.
    assign w_keep      = w_grant_go ? w_pick : r_active;
    assign w_pend_next = mute ? '0 :
        (((r_pending & ~(w_final ? r_active : '0)) | req) & ~(flush ? ~w_keep : '0));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_active     <= '0;
            r_play_id    <= '0;
            r_reps_m1    <= '0;
            r_rep_cnt    <= '0;
            r_play_start <= 1'b0;
            r_play_stop  <= 1'b0;
            r_gap        <= '0;
            r_wd         <= '0;
        end else begin
            r_pending    <= w_pend_next;
            r_play_start <= 1'b0;
            r_play_stop  <= 1'b0;
            // Counts cycles since play_start; the start transitions below reload it.
            if ((TIMEOUT != 0) && ((r_state == ST_START) || (r_state == ST_PLAY))) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_abort) begin
                r_play_stop <= 1'b1;
                r_active    <= '0;
                r_state     <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_grant_go) begin
                            r_active     <= w_pick;
                            r_play_id    <= w_pick_id;
                            r_reps_m1    <= w_pick_reps;
                            r_rep_cnt    <= '0;
                            r_play_start <= 1'b1;
                            r_wd         <= '0;
                            r_state      <= ST_START;
                        end
                    end
                    ST_START: r_state <= ST_PLAY;
                    ST_PLAY: begin
                        if (w_done) begin
                            if (r_rep_cnt != 2'd3) begin
                                r_rep_cnt <= r_rep_cnt + 2'd1;
                            end
                            r_play_stop <= w_timeout && !play_done;
                            if (w_final) begin
                                r_active <= '0;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_gap   <= GAP_W'(GAP_CYCLES - 1);
                                r_state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (r_gap == '0) begin
                            r_play_start <= 1'b1;
                            r_wd         <= '0;
                            r_state      <= ST_START;
                        end else begin
                            r_gap <= r_gap - 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign play_start = r_play_start;
    assign play_stop  = r_play_stop;
    assign play_id    = r_play_id;
    assign busy       = (r_state != ST_IDLE);
    assign active_req = r_active;
    assign rep_cnt    = r_rep_cnt;

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler: table-driven grants plus hand-written
// flush, replay, mute, watchdog and reset sequences, with a start/stop event scoreboard.
module tb_sound_scheduler;

    localparam int GAP = 4;
    localparam int TMO = 20;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       flush = 1'b0;
    logic       mute = 1'b0;
    logic       play_done = 1'b0;
    logic       play_start;
    logic       play_stop;
    logic [2:0] play_id;
    logic       busy;
    logic [3:0] active_req;
    logic [1:0] rep_cnt;

    // Expected clip table, written independently of the design package.
    int exp_id   [4] = '{5, 2, 3, 6};
    int exp_reps [4] = '{1, 2, 3, 4};

    sound_scheduler #(
        .N_REQ(4), .ID_W(3), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .req(req), .flush(flush), .mute(mute),
        .play_start(play_start), .play_stop(play_stop), .play_id(play_id),
        .play_done(play_done), .busy(busy), .active_req(active_req), .rep_cnt(rep_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_stop;
        int at;
        int id;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [3:0] req;
        int first_idx;
        int second_idx;
        int len;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input bit s, input int at, input int id);
        ev_t e;
        e.is_stop = s;
        e.at = at;
        e.id = id;
        sb.push_back(e);
    endtask

    // Scoreboard: pop an expected event whenever the DUT pulses start or stop.
    always @(negedge CLK) begin
        ev_t e;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            chk("ev_missed", cyc, sb[0].at);
            void'(sb.pop_front());
        end
        if (play_start || play_stop) begin
            if (sb.size() == 0) begin
                chk("ev_unexpected", int'({play_start, play_stop}), 0);
            end else begin
                e = sb.pop_front();
                chk("ev_kind", int'(play_stop), int'(e.is_stop));
                chk("ev_cycle", cyc, e.at);
                if (!e.is_stop) chk("ev_id", int'(play_id), e.id);
                $display("event %s cycle %0d id %0d active %b rep %0d",
                         play_stop ? "stop " : "start", cyc, play_id, active_req, rep_cnt);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_until(input int c);
        if (cyc > c) chk("sched_late", cyc, c);
        while (cyc < c) step();
    endtask

    task automatic serve(input int idx, input int t_start, input int len, output int t_last);
        int s;
        s = t_start;
        t_last = t_start;
        push_ev(1'b0, s, exp_id[idx]);
        wait_until(s);
        chk("active_req", int'(active_req), 1 << idx);
        chk("busy_start", int'(busy), 1);
        chk("rep_cnt_start", int'(rep_cnt), 0);
        for (int r = 1; r <= exp_reps[idx]; r++) begin
            wait_until(s + len);
            play_done = 1'b1;
            step();
            play_done = 1'b0;
            t_last = s + len;
            chk("rep_cnt", int'(rep_cnt), (r > 3) ? 3 : r);
            chk("busy_after_done", int'(busy), (r == exp_reps[idx]) ? 0 : 1);
            if (r < exp_reps[idx]) begin
                s = s + len + GAP + 1;
                push_ev(1'b0, s, exp_id[idx]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int t;
        int s;
        int tl;

        vecs[0] = '{4'b0100, 2, -1, 10};
        vecs[1] = '{4'b0001, 0, -1, 3};
        vecs[2] = '{4'b1000, 3, -1, 2};
        vecs[3] = '{4'b1010, 1, 3, 3};
        vecs[4] = '{4'b0101, 0, 2, 1};

        step(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active", int'(active_req), 0);
        chk("rst_play_id", int'(play_id), 0);
        chk("rst_start_stop", int'({play_start, play_stop}), 0);
        rst_n = 1'b1;
        step(2);

        for (int v = 0; v < 5; v++) begin
            t = cyc;
            req = vecs[v].req;
            step();
            req = 4'b0;
            serve(vecs[v].first_idx, t + 2, vecs[v].len, tl);
            if (vecs[v].second_idx >= 0) serve(vecs[v].second_idx, tl + 2, vecs[v].len, tl);
            step(3);
            chk("idle_after_vec", int'(busy), 0);
        end

        // Flush while idx0 plays drops pending idx2.
        t = cyc;
        req = 4'b0001;
        step();
        req = 4'b0;
        push_ev(1'b0, t + 2, exp_id[0]);
        wait_until(t + 4);
        req = 4'b0100;
        step();
        req = 4'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_until(t + 10);
        play_done = 1'b1;
        step();
        play_done = 1'b0;
        chk("flush_busy_done", int'(busy), 0);
        step(8);
        chk("flush_busy_later", int'(busy), 0);
        chk("flush_active", int'(active_req), 0);

        // Flush and request on the same index in the same cycle: dropped.
        req = 4'b0100;
        flush = 1'b1;
        step();
        req = 4'b0;
        flush = 1'b0;
        step(4);
        chk("flush_req_drop", int'(busy), 0);

        // Request on the granted index together with its final done: replays.
        t = cyc;
        req = 4'b0001;
        step();
        req = 4'b0;
        push_ev(1'b0, t + 2, exp_id[0]);
        wait_until(t + 5);
        play_done = 1'b1;
        req = 4'b0001;
        step();
        play_done = 1'b0;
        req = 4'b0;
        push_ev(1'b0, t + 7, exp_id[0]);
        chk("replay_idle", int'(busy), 0);
        wait_until(t + 9);
        play_done = 1'b1;
        step();
        play_done = 1'b0;
        chk("replay_done", int'(busy), 0);
        step(3);

        // Mute mid-play aborts, and requests during mute are ignored.
        t = cyc;
        req = 4'b0100;
        step();
        req = 4'b0;
        push_ev(1'b0, t + 2, exp_id[2]);
        wait_until(t + 5);
        mute = 1'b1;
        push_ev(1'b1, t + 6, 0);
        step();
        chk("mute_busy", int'(busy), 0);
        chk("mute_active", int'(active_req), 0);
        step();
        req = 4'b0010;
        step();
        req = 4'b0;
        step();
        mute = 1'b0;
        step(6);
        chk("mute_no_restart", int'(busy), 0);

        // Watchdog: no done from the player.
        t = cyc;
        req = 4'b0010;
        step();
        req = 4'b0;
        s = t + 2;
        push_ev(1'b0, s, exp_id[1]);
        push_ev(1'b1, s + TMO, 0);
        push_ev(1'b0, s + TMO + GAP, exp_id[1]);
        wait_until(s + TMO);
        chk("wd_rep_cnt", int'(rep_cnt), 1);
        chk("wd_busy_gap", int'(busy), 1);
        wait_until(s + TMO + GAP + 3);
        play_done = 1'b1;
        step();
        play_done = 1'b0;
        chk("wd_rep_cnt_final", int'(rep_cnt), 2);
        chk("wd_busy_final", int'(busy), 0);
        step(3);

        // Asynchronous reset in the middle of a gap.
        t = cyc;
        req = 4'b0100;
        step();
        req = 4'b0;
        s = t + 2;
        push_ev(1'b0, s, exp_id[2]);
        wait_until(s + 2);
        play_done = 1'b1;
        step();
        play_done = 1'b0;
        step();
        chk("pre_reset_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_active", int'(active_req), 0);
        chk("arst_rep_cnt", int'(rep_cnt), 0);
        chk("arst_play_id", int'(play_id), 0);
        chk("arst_start_stop", int'({play_start, play_stop}), 0);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("post_reset_idle", int'(busy), 0);
        t = cyc;
        req = 4'b0001;
        step();
        req = 4'b0;
        serve(0, t + 2, 2, tl);
        step(3);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
